rtype_control_unit: RTL

- Hard-wired Moore control sequencer for the single-bus datapath.
- Repeatedly fetches instructions (T0–T2) and executes register-format ALU instructions (T3–T6) by driving the datapath's one-hot register enables and unit strobes.
- Sits beside the datapath in the top level. It reads IR, drives every datapath control input, and handshakes with memory through mem_ready.
- Replaces the hand-written per-instruction state sequences used in unit benches.

---
 rtl/cpu_ctrl_pkg.sv | 77 +++++++
 rtl/reg_select_decoder.sv | 17 +
 rtl/rtype_control_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus datapath control sequencer:
// state encoding, opcode and ALU select constants, IR field positions.
package cpu_ctrl_pkg;

    // Sequencer states: IDLE, fetch T0..T2, execute T3..T6, sticky HALT.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    // Opcodes (IR[31:27]); 12..30 are illegal.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_ROR  = 5'd6;
    localparam logic [4:0] OP_ROL  = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_NEG  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_HALT = 5'd31;

    // ALU select codes; numerically equal to the low opcode bits.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    // IR field bit positions.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcodes 0..11 are register-format ALU instructions.
    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= OP_NOT;
    endfunction

    // Single-operand ops skip the Y load and T4.
    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Double-width results need the extra HI write-back cycle.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // ALU select for a legal ALU opcode.
    function automatic logic [3:0] alu_sel(input logic [4:0] op);
        return op[3:0];
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index plus enable to a 16-bit one-hot select.
module reg_select_decoder (
    input  logic [3:0]  index,
    input  logic        enable,
    output logic [15:0] onehot
);

    // One-hot decode; all zero when not enabled.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        onehot = '0;
        if (enable) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/rtype_control_unit.sv
// Hard-wired Moore sequencer: fetches instructions (T0-T2) and executes
// register-format ALU instructions (T3-T6) on the single-bus datapath.
module rtype_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic [15:0]      Rin,
    output logic [15:0]      Rout,
    output logic             PCin,
    output logic             PCout,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Zhighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [3:0]       ALUop,
    output logic             instr_done,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       rin_en, rout_en;
    logic [3:0] rout_idx;
    logic       unused_ir;

    assign op        = IR[OP_MSB:OP_LSB];
    assign ra        = IR[RA_MSB:RA_LSB];
    assign rb        = IR[RB_MSB:RB_LSB];
    assign rc        = IR[RC_MSB:RC_LSB];
    assign unused_ir = ^IR[RC_LSB-1:0];

    // Moore output decode from the registered state and the loaded IR.
    always_comb begin
        PCin       = 1'b0;
        PCout      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        ALUop      = '0;
        instr_done = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_idx   = rb;
        case (state)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            ST_T1: begin
                // Held during a memory stall; reloading PC from the same Z is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_unary(op)) begin
                    rout_en = 1'b1;
                    ALUop   = alu_sel(op);
                    Zlowin  = 1'b1;
                end else if (is_alu_op(op)) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                ALUop    = alu_sel(op);
                Zlowin   = 1'b1;
                Zhighin  = is_muldiv(op);
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(op)) begin
                    LOin = 1'b1;
                end else begin
                    rin_en     = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder u_rin_dec (
        .index  (ra),
        .enable (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder u_rout_dec (
        .index  (rout_idx),
        .enable (rout_en),
        .onehot (Rout)
    );

    // State sequencing, halt flag and retired-instruction counter.
    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state       <= ST_IDLE;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (state)
                ST_IDLE: if (run) state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   if (mem_ready) state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3: begin
                    if (!is_alu_op(op)) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (is_unary(op)) begin
                        state <= ST_T5;
                    end else begin
                        state <= ST_T4;
                    end
                end
                ST_T4:   state <= ST_T5;
                ST_T5: begin
                    if (is_muldiv(op)) state <= ST_T6;
                    else               state <= run ? ST_T0 : ST_IDLE;
                end
                ST_T6:   state <= run ? ST_T0 : ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
